// File: rtl/cheshire_fixture_pkg.sv
// ----------------------------------------------------------------------------
// cheshire_fixture_pkg
//   Shared definitions for the Cheshire SoC simulation fixture:
//   register offsets, strap/mode enums and the dump FSM state encoding.
//   No ports; imported by cheshire_soc_fixture and cheshire_fixture_dump_fsm.
// ----------------------------------------------------------------------------
package cheshire_fixture_pkg;

    // Register map (byte offsets of 32-bit words)
    localparam logic [7:0] ADDR_SCRATCH_FIRST = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH_LAST  = 8'h3C;
    localparam logic [7:0] ADDR_BOOT_MODE     = 8'h40;
    localparam logic [7:0] ADDR_PRELOAD_MODE  = 8'h44;
    localparam logic [7:0] ADDR_HW_CFG        = 8'h48;

    localparam int unsigned NUM_SCRATCH = 16;

    // Scratch word that carries the EOC flag (bit 0) and exit code (bits 31:1)
    localparam int unsigned EOC_SCRATCH_IDX = 2;

    typedef enum logic [1:0] {
        VCD_OFF       = 2'd0,
        VCD_ALWAYS    = 2'd1,
        VCD_TRIGGERED = 2'd2,
        VCD_RESERVED  = 2'd3
    } vcd_mode_e;

    typedef enum logic [2:0] {
        BOOT_IDLE     = 3'd0,
        BOOT_SD       = 3'd1,
        BOOT_AUTO_SPI = 3'd2,
        BOOT_AUTO_I2C = 3'd3,
        BOOT_FORCE    = 3'd4
    } boot_mode_e;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_INIT = 2'd1,
        DUMP_WAIT = 2'd2,
        DUMP_OFF  = 2'd3
    } dump_state_e;

    // True for any address inside the scratch window (alignment checked separately)
    function automatic logic is_scratch_addr(input logic [7:0] addr);
        return (addr >= ADDR_SCRATCH_FIRST) && (addr <= ADDR_SCRATCH_LAST);
    endfunction

    // True only for the exact word offsets of the read-only status registers
    function automatic logic is_ro_addr(input logic [7:0] addr);
        return (addr == ADDR_BOOT_MODE) || (addr == ADDR_PRELOAD_MODE) ||
               (addr == ADDR_HW_CFG);
    endfunction

endpackage

// File: rtl/cheshire_fixture_dump_fsm.sv
// ----------------------------------------------------------------------------
// cheshire_fixture_dump_fsm
//   Sequences waveform-dump windows. Opens a window (start pulse) when the
//   dump mode is unconditional, or triggered with the trigger high; closes it
//   (stop pulse) when a triggered window loses its trigger.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   vcd_mode_i      0 off, 1 unconditional, 2 triggered, 3 off
//   trigger_i       dump trigger (scratch[2] bit 0)
//   dump_start_o    one-cycle pulse while opening a dump file
//   dump_stop_o     one-cycle pulse while closing a dump file
//   dump_seq_o      number of windows opened so far (file index)
// ----------------------------------------------------------------------------
module cheshire_fixture_dump_fsm
    import cheshire_fixture_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  vcd_mode_i,
    input  logic        trigger_i,
    output logic        dump_start_o,
    output logic        dump_stop_o,
    output logic [31:0] dump_seq_o
);

    dump_state_e state_q;
    vcd_mode_e   mode;

    assign mode = vcd_mode_e'(vcd_mode_i);

    // Pulses are registered alongside the state so that dump_start_o is high
    // exactly while in INIT and dump_stop_o exactly while in OFF. The sequence
    // number advances on leaving INIT, so during the start pulse it still
    // shows the index of the window being opened.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= DUMP_IDLE;
            dump_start_o <= 1'b0;
            dump_stop_o  <= 1'b0;
            dump_seq_o   <= '0;
        end else begin
            dump_start_o <= 1'b0;
            dump_stop_o  <= 1'b0;
            case (state_q)
                DUMP_IDLE: begin
                    if ((mode == VCD_ALWAYS) || ((mode == VCD_TRIGGERED) && trigger_i)) begin
                        state_q      <= DUMP_INIT;
                        dump_start_o <= 1'b1;
                    end
                end
                DUMP_INIT: begin
                    dump_seq_o <= dump_seq_o + 32'd1;
                    state_q    <= DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    // Leaving via a mode change abandons the window silently
                    if (mode == VCD_TRIGGERED) begin
                        if (!trigger_i) begin
                            state_q     <= DUMP_OFF;
                            dump_stop_o <= 1'b1;
                        end
                    end else if (mode != VCD_ALWAYS) begin
                        state_q <= DUMP_IDLE;
                    end
                end
                DUMP_OFF: begin
                    state_q <= DUMP_IDLE;
                end
                default: begin
                    state_q <= DUMP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/cheshire_soc_fixture.sv
// ----------------------------------------------------------------------------
// cheshire_soc_fixture
//   Simulation-side control/status block for the Cheshire SoC harness.
//   Scratch register file, read-only strap/build-option registers, sticky
//   end-of-computation detection, exit code, and dump-window sequencing.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   boot_mode_i              boot strap
//   preload_mode_i           preload strap
//   vcd_mode_i               waveform dump mode
//   req_i, we_i, addr_i,
//   wdata_i, be_i            register bus request (zero latency)
//   rdata_o, err_o           combinational response
//   eoc_o                    sticky end of computation
//   exit_code_o              scratch[2] >> 1
//   vcd_trigger_o            scratch[2] bit 0
//   dump_start_o/stop_o/seq_o dump window control
// ----------------------------------------------------------------------------
module cheshire_soc_fixture
    import cheshire_fixture_pkg::*;
#(
    parameter int unsigned SelectedCfg = 0,
    parameter bit          UseDramSys  = 1'b0,
    parameter bit          UseJtagDPI  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [2:0]  boot_mode_i,
    input  logic [1:0]  preload_mode_i,
    input  logic [1:0]  vcd_mode_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        eoc_o,
    output logic [31:0] exit_code_o,
    output logic        vcd_trigger_o,
    output logic        dump_start_o,
    output logic        dump_stop_o,
    output logic [31:0] dump_seq_o
);

    localparam logic [7:0]  SEL_CFG_BYTE = 8'(SelectedCfg);
    localparam logic [31:0] HW_CFG_VAL   = {16'b0, SEL_CFG_BYTE, 6'b0, UseJtagDPI, UseDramSys};

    logic [31:0] scratch_q [NUM_SCRATCH];
    logic        hit_scratch;
    logic        hit_ro;
    logic        do_write;
    logic        do_read;

    // Address decode and error detection. A misaligned address inside the
    // scratch window is still an error; RO registers only match exact words.
    always_comb begin
        hit_scratch = is_scratch_addr(addr_i);
        hit_ro      = is_ro_addr(addr_i);
        err_o       = req_i && ((addr_i[1:0] != 2'b00) ||
                                !(hit_scratch || hit_ro) ||
                                (we_i && hit_ro));
        do_write    = req_i && we_i && !err_o;
        do_read     = req_i && !we_i && !err_o;
    end

    // Read mux: scratch contents are the pre-edge values, so a read always
    // sees the state before any write landing at the coming edge.
    always_comb begin
        rdata_o = '0;
        if (do_read) begin
            if (hit_scratch) begin
                rdata_o = scratch_q[addr_i[5:2]];
            end else begin
                case (addr_i)
                    ADDR_BOOT_MODE:    rdata_o = {29'b0, boot_mode_i};
                    ADDR_PRELOAD_MODE: rdata_o = {30'b0, preload_mode_i};
                    ADDR_HW_CFG:       rdata_o = HW_CFG_VAL;
                    default:           rdata_o = '0;
                endcase
            end
        end
    end

    // Scratch register file with per-byte write enables
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    scratch_q[addr_i[5:2]][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // EOC latches the registered flag one edge after it appears and holds
    // until reset, so software clearing bit 0 cannot retract completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eoc_o <= 1'b0;
        end else if (scratch_q[EOC_SCRATCH_IDX][0]) begin
            eoc_o <= 1'b1;
        end
    end

    assign exit_code_o   = {1'b0, scratch_q[EOC_SCRATCH_IDX][31:1]};
    assign vcd_trigger_o = scratch_q[EOC_SCRATCH_IDX][0];

    cheshire_fixture_dump_fsm u_dump_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .vcd_mode_i   (vcd_mode_i),
        .trigger_i    (vcd_trigger_o),
        .dump_start_o (dump_start_o),
        .dump_stop_o  (dump_stop_o),
        .dump_seq_o   (dump_seq_o)
    );

endmodule

// File: tb/tb_cheshire_soc_fixture.sv
// ----------------------------------------------------------------------------
// tb_cheshire_soc_fixture
//   Self-checking bench for cheshire_soc_fixture with a behavioural model of
//   the register file, EOC flag and dump windows.
// ----------------------------------------------------------------------------
module tb_cheshire_soc_fixture;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [2:0]  boot_mode_i;
    logic [1:0]  preload_mode_i;
    logic [1:0]  vcd_mode_i;
    logic        req_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        eoc_o;
    logic [31:0] exit_code_o;
    logic        vcd_trigger_o;
    logic        dump_start_o;
    logic        dump_stop_o;
    logic [31:0] dump_seq_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_scr [16];
    bit          m_eoc;
    int          m_phase;    // 0 closed, 1 opening, 2 open, 3 closing
    int unsigned m_seq;

    always #5 clk_i = ~clk_i;

    cheshire_soc_fixture #(
        .SelectedCfg (5),
        .UseDramSys  (1'b1),
        .UseJtagDPI  (1'b0)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .boot_mode_i    (boot_mode_i),
        .preload_mode_i (preload_mode_i),
        .vcd_mode_i     (vcd_mode_i),
        .req_i          (req_i),
        .we_i           (we_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .be_i           (be_i),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .eoc_o          (eoc_o),
        .exit_code_o    (exit_code_o),
        .vcd_trigger_o  (vcd_trigger_o),
        .dump_start_o   (dump_start_o),
        .dump_stop_o    (dump_stop_o),
        .dump_seq_o     (dump_seq_o)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input bit r, input bit w, input logic [7:0] a);
        bit ro;
        ro = (a == 8'h40) || (a == 8'h44) || (a == 8'h48);
        return r && ((a % 4 != 0) || !((a < 8'h40) || ro) || (w && ro));
    endfunction

    function automatic logic [31:0] model_rdata(input bit r, input bit w, input logic [7:0] a);
        if (!r || w || model_err(r, w, a)) return 32'h0;
        if (a < 8'h40) return m_scr[a / 4];
        if (a == 8'h40) return 32'(boot_mode_i);
        if (a == 8'h44) return 32'(preload_mode_i);
        return (5 << 8) | 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_scr[i] = 32'h0;
        m_eoc   = 1'b0;
        m_phase = 0;
        m_seq   = 0;
    endtask

    // Everything the design does at one rising edge, using pre-edge values
    task automatic model_edge();
        bit trig;
        trig = m_scr[2][0];
        if (trig) m_eoc = 1'b1;
        case (m_phase)
            0: if (vcd_mode_i == 2'd1 || (vcd_mode_i == 2'd2 && trig)) m_phase = 1;
            1: begin m_seq = m_seq + 1; m_phase = 2; end
            2: begin
                if (vcd_mode_i == 2'd2) begin
                    if (!trig) m_phase = 3;
                end else if (vcd_mode_i != 2'd1) begin
                    m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
        if (req_i && we_i && !model_err(req_i, we_i, addr_i)) begin
            for (int b = 0; b < 4; b++)
                if (be_i[b]) m_scr[addr_i / 4][8*b +: 8] = wdata_i[8*b +: 8];
        end
    endtask

    task automatic checkOutput();
        check32("eoc",       32'(eoc_o),         32'(m_eoc));
        check32("exit_code", exit_code_o,        m_scr[2] >> 1);
        check32("vcd_trig",  32'(vcd_trigger_o), 32'(m_scr[2][0]));
        check32("start",     32'(dump_start_o),  32'(m_phase == 1));
        check32("stop",      32'(dump_stop_o),   32'(m_phase == 3));
        check32("seq",       dump_seq_o,         m_seq);
    endtask

    // Drive one bus request and check the combinational response
    task automatic applyStimulus(input bit r, input bit w, input logic [7:0] a,
                                 input logic [31:0] d, input logic [3:0] b);
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        wdata_i = d;
        be_i    = b;
        #1;
        check32("err",   32'(err_o), 32'(model_err(r, w, a)));
        check32("rdata", rdata_o,    model_rdata(r, w, a));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
            step();
        end
    endtask

    task automatic releaseReset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;

        rst_ni         = 1'b0;
        boot_mode_i    = 3'd4;
        preload_mode_i = 2'd2;
        vcd_mode_i     = 2'd0;
        req_i          = 1'b0;
        we_i           = 1'b0;
        addr_i         = 8'h00;
        wdata_i        = 32'h0;
        be_i           = 4'h0;
        model_reset();
        #1;
        checkOutput();
        releaseReset();

        // Read-only registers and reset contents
        applyStimulus(1'b1, 1'b0, 8'h48, 32'h0, 4'h0);
        check32("hw_cfg", rdata_o, 32'h0000_0501);
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
        check32("scratch8_reset", rdata_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 8'h44, 32'h0, 4'h0);
        step();

        // EOC sequence
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h0, 4'hF);
        step();
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h1, 4'hF);
        step();
        check32("eoc_not_yet", 32'(eoc_o), 32'h0);
        idleCycles(1);
        check32("eoc_set", 32'(eoc_o), 32'h1);
        check32("exit_zero", exit_code_o, 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h55, 4'hF);
        step();
        check32("exit_2a", exit_code_o, 32'h2A);
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h0, 4'hF);
        step();
        check32("eoc_sticky", 32'(eoc_o), 32'h1);

        // Byte enables and error cases
        applyStimulus(1'b1, 1'b1, 8'h04, 32'hAABBCCDD, 4'b0010);
        step();
        applyStimulus(1'b1, 1'b0, 8'h04, 32'h0, 4'h0);
        check32("be_byte1", rdata_o, 32'h0000_CC00);
        applyStimulus(1'b1, 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF);
        check32("ro_write_err", 32'(err_o), 32'h1);
        step();
        applyStimulus(1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
        check32("ro_unchanged", rdata_o, 32'h4);
        applyStimulus(1'b1, 1'b0, 8'h4C, 32'h0, 4'h0);
        check32("unmapped_err", 32'(err_o), 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h05, 32'h0, 4'h0);
        check32("misaligned_err", 32'(err_o), 32'h1);
        step();

        // Randomised bus traffic against the model (dumps off)
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom_range(0, 8'h4F));
            if ($urandom_range(0, 3) != 0) ra = ra & 8'hFC;
            rd = $urandom;
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), ra, rd, 4'($urandom_range(0, 15)));
            step();
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i * 4), 32'h0, 4'h0);
            step();
        end

        // Triggered dump windows
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h0, 4'hF);
        step();
        idleCycles(2);
        vcd_mode_i = 2'd2;
        idleCycles(2);
        check32("trig_idle_seq", dump_seq_o, 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h1, 4'hF);
        step();
        idleCycles(9);
        check32("window1_seq", dump_seq_o, 32'h1);
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h0, 4'hF);
        step();
        idleCycles(5);
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h1, 4'hF);
        step();
        idleCycles(4);
        check32("window2_seq", dump_seq_o, 32'h2);

        // Asynchronous reset while a window is open
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        checkOutput();
        applyStimulus(1'b1, 1'b0, 8'h08, 32'h0, 4'h0);
        check32("scratch2_after_rst", rdata_o, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

        // Unconditional mode after reset, then leave WAIT by mode change
        vcd_mode_i = 2'd1;
        releaseReset();
        idleCycles(1);
        check32("always_start", 32'(dump_start_o), 32'h1);
        idleCycles(6);
        check32("always_seq", dump_seq_o, 32'h1);
        vcd_mode_i = 2'd3;
        idleCycles(4);

        // Mode off: no pulses at all
        #2;
        rst_ni = 1'b0;
        model_reset();
        vcd_mode_i = 2'd0;
        #1;
        checkOutput();
        releaseReset();
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h1, 4'hF);
        step();
        idleCycles(6);
        check32("off_seq", dump_seq_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
